// File: rtl/dfdd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfdd_pkg
// Description : Shared widths, exponent bias and coordinate type for the
//               DFDD pixel front end.
// Revision    : 1.0
// ============================================================================
package dfdd_pkg;

    localparam int COORD_WIDTH = 16;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    typedef struct packed {
        logic [COORD_WIDTH-1:0] col;
        logic [COORD_WIDTH-1:0] row;
    } pixel_coord_t;

endpackage
`default_nettype wire

// File: rtl/uint8_to_fp.sv
`default_nettype none
// ============================================================================
// Module      : uint8_to_fp
// Description : Two-stage exact conversion of an 8-bit unsigned pixel to a
//               sign/exponent/fraction float word.
// Revision    : 1.0
// ============================================================================
module uint8_to_fp
    import dfdd_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    input  logic [7:0]                     pix_i,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]  fp_o
);

    localparam int FP_WIDTH = fp_width(EXP_WIDTH, FRAC_WIDTH);
    localparam logic [EXP_WIDTH-1:0] c_bias = EXP_WIDTH'(exp_bias(EXP_WIDTH));

    logic [7:0]            r_pix;
    logic [2:0]            r_pos;
    logic                  r_valid;
    logic [FP_WIDTH-1:0]   r_fp;

    logic [2:0]            w_pos;
    logic [6:0]            w_mant;
    logic [FRAC_WIDTH-1:0] w_frac;
    logic [EXP_WIDTH-1:0]  w_exp;
    logic [FP_WIDTH-1:0]   w_fp;

    // Leading-one priority encoder: highest set bit wins.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < 8; i++) begin
            if (pix_i[i]) begin
                w_pos = 3'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_pix   <= '0;
            r_pos   <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_pix <= pix_i;
                r_pos <= w_pos;
            end
        end
    end

    // Shifting the leading one to bit 7 leaves the fraction bits left-aligned below it.
    assign w_mant = 7'(r_pix << (3'd7 - r_pos));
    assign w_exp  = c_bias + EXP_WIDTH'(r_pos);

    generate
        if (FRAC_WIDTH == 7) begin : g_frac_exact
            assign w_frac = w_mant;
        end else begin : g_frac_pad
            assign w_frac = {w_mant, {(FRAC_WIDTH-7){1'b0}}};
        end
    endgenerate

    assign w_fp = (r_pix == 8'd0) ? '0 : {1'b0, w_exp, w_frac};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fp <= '0;
        end else if (r_valid) begin
            r_fp <= w_fp;
        end
    end

    assign fp_o = r_fp;

endmodule
`default_nettype wire

// File: rtl/dfdd_pixel_frontend.sv
`default_nettype none
// ============================================================================
// Module      : dfdd_pixel_frontend
// Description : Converts paired rho-plus/rho-minus pixels to float and tags
//               each with its column/row, eof and frame-error sideband.
// Revision    : 1.0
// ============================================================================
module dfdd_pixel_frontend
    import dfdd_pkg::*;
#(
    parameter int EXP_WIDTH    = 8,
    parameter int FRAC_WIDTH   = 23,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              rho_plus_uint8_i,
    input  logic [7:0]              rho_minus_uint8_i,
    input  logic                    valid_i,
    input  logic                    sof_i,
    output logic [FP_WIDTH_REG-1:0] i_rho_plus_o,
    output logic [FP_WIDTH_REG-1:0] i_rho_minus_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    eof_o,
    output logic                    frame_err_o
);

    localparam logic [15:0] c_last_col = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] c_last_row = 16'(IMAGE_HEIGHT - 1);

    pixel_coord_t r_cnt;
    pixel_coord_t w_cur;
    pixel_coord_t w_nxt;
    logic         w_eof;
    logic         w_err;

    pixel_coord_t r_s1_coord;
    logic         r_s1_valid;
    logic         r_s1_eof;
    logic         r_s1_err;

    pixel_coord_t r_s2_coord;
    logic         r_s2_valid;
    logic         r_s2_eof;
    logic         r_s2_err;

    uint8_to_fp #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_conv_plus (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .pix_i   (rho_plus_uint8_i),
        .fp_o    (i_rho_plus_o)
    );

    uint8_to_fp #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_conv_minus (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .pix_i   (rho_minus_uint8_i),
        .fp_o    (i_rho_minus_o)
    );

    // sof forces the current pixel to (0,0); eof is judged on that assigned coordinate.
    always_comb begin
        w_cur = sof_i ? '0 : r_cnt;
        w_nxt = w_cur;
        if (w_cur.col == c_last_col) begin
            w_nxt.col = '0;
            w_nxt.row = (w_cur.row == c_last_row) ? '0 : w_cur.row + 16'd1;
        end else begin
            w_nxt.col = w_cur.col + 16'd1;
        end
        w_eof = (w_cur.col == c_last_col) && (w_cur.row == c_last_row);
        w_err = sof_i && (r_cnt != '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt      <= '0;
            r_s1_coord <= '0;
            r_s1_valid <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_cnt      <= w_nxt;
                r_s1_coord <= w_cur;
                r_s1_eof   <= w_eof;
                r_s1_err   <= w_err;
            end
        end
    end

    // Flags are pulses aligned to valid_o; coordinates hold across gaps like the data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_s2_coord <= '0;
            r_s2_valid <= 1'b0;
            r_s2_eof   <= 1'b0;
            r_s2_err   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_eof   <= r_s1_valid & r_s1_eof;
            r_s2_err   <= r_s1_valid & r_s1_err;
            if (r_s1_valid) begin
                r_s2_coord <= r_s1_coord;
            end
        end
    end

    assign col_o       = r_s2_coord.col;
    assign row_o       = r_s2_coord.row;
    assign valid_o     = r_s2_valid;
    assign eof_o       = r_s2_eof;
    assign frame_err_o = r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_dfdd_pixel_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfdd_pixel_frontend
// Description : Directed bench for two front-end configurations against a
//               behavioural raster/float model.
// Revision    : 1.0
// ============================================================================
module tb_dfdd_pixel_frontend;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  rp = '0;
    logic [7:0]  rm = '0;
    logic        vin = 1'b0;
    logic        sof = 1'b0;

    logic [31:0] p0, m0;
    logic [15:0] p1, m1;
    logic [15:0] c0, r0, c1, r1;
    logic        v0, v1, e0, e1, f0, f1;

    int checks = 0;
    int errors = 0;
    int eof_cnt = 0;
    logic count_en = 1'b0;

    always #5 clk = ~clk;

    dfdd_pixel_frontend #(
        .EXP_WIDTH(8), .FRAC_WIDTH(23), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3)
    ) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .rho_plus_uint8_i(rp), .rho_minus_uint8_i(rm),
        .valid_i(vin), .sof_i(sof),
        .i_rho_plus_o(p0), .i_rho_minus_o(m0),
        .col_o(c0), .row_o(r0), .valid_o(v0), .eof_o(e0), .frame_err_o(f0)
    );

    dfdd_pixel_frontend #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .rho_plus_uint8_i(rp), .rho_minus_uint8_i(rm),
        .valid_i(vin), .sof_i(sof),
        .i_rho_plus_o(p1), .i_rho_minus_o(m1),
        .col_o(c1), .row_o(r1), .valid_o(v1), .eof_o(e1), .frame_err_o(f1)
    );

    typedef struct {
        logic        valid;
        logic [31:0] p;
        logic [31:0] m;
        int          col;
        int          row;
        logic        eof;
        logic        err;
    } exp_t;

    int   W[2] = '{4, 1};
    int   H[2] = '{3, 1};
    int   E[2] = '{8, 5};
    int   F[2] = '{23, 10};
    exp_t s1[2];
    exp_t s2[2];
    int   mcol[2];
    int   mrow[2];

    function automatic logic [31:0] to_fp(input int v, input int ew, input int fw);
        int     p;
        longint ex;
        longint frac;
        if (v == 0) return 32'd0;
        p = 0;
        while ((1 << (p + 1)) <= v) p++;
        ex   = longint'((1 << (ew - 1)) - 1 + p);
        frac = longint'(v - (1 << p)) << (fw - p);
        return 32'((ex << fw) | frac);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Raster model: linear pixel index within the frame, float via plain arithmetic.
    always @(posedge clk or negedge rst_i) begin : model
        exp_t e;
        int   c, r, idx;
        if (!rst_i) begin
            for (int k = 0; k < 2; k++) begin
                s1[k]   <= '{default: 0};
                s2[k]   <= '{default: 0};
                mcol[k] <= 0;
                mrow[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                s2[k]   <= s1[k];
                e       = s1[k];
                e.valid = vin;
                if (vin) begin
                    e.err   = sof && (mcol[k] != 0 || mrow[k] != 0);
                    c       = sof ? 0 : mcol[k];
                    r       = sof ? 0 : mrow[k];
                    e.col   = c;
                    e.row   = r;
                    e.eof   = (c == W[k] - 1) && (r == H[k] - 1);
                    e.p     = to_fp(int'(rp), E[k], F[k]);
                    e.m     = to_fp(int'(rm), E[k], F[k]);
                    idx     = (r * W[k] + c + 1) % (W[k] * H[k]);
                    mcol[k] <= idx % W[k];
                    mrow[k] <= idx / W[k];
                end
                s1[k] <= e;
            end
        end
    end

    task automatic cmp_dut(input int k, input logic v, input logic [31:0] p, input logic [31:0] m,
                           input logic [15:0] c, input logic [15:0] r, input logic e, input logic f);
        chk($sformatf("d%0d valid_o", k), 32'(v), 32'(s2[k].valid));
        if (s2[k].valid) begin
            chk($sformatf("d%0d rho_plus", k), p, s2[k].p);
            chk($sformatf("d%0d rho_minus", k), m, s2[k].m);
            chk($sformatf("d%0d col", k), 32'(c), 32'(s2[k].col));
            chk($sformatf("d%0d row", k), 32'(r), 32'(s2[k].row));
            chk($sformatf("d%0d eof", k), 32'(e), 32'(s2[k].eof));
            chk($sformatf("d%0d frame_err", k), 32'(f), 32'(s2[k].err));
        end else begin
            chk($sformatf("d%0d eof idle", k), 32'(e), 32'd0);
            chk($sformatf("d%0d frame_err idle", k), 32'(f), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) begin
            cmp_dut(0, v0, p0, m0, c0, r0, e0, f0);
            cmp_dut(1, v1, 32'(p1), 32'(m1), c1, r1, e1, f1);
            if (count_en && e0) eof_cnt++;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
        rp  = a;
        rm  = b;
        vin = 1'b1;
        sof = s;
        @(posedge clk);
        #2;
        vin = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", 32'(v0), 32'd0);
        chk("reset rho_plus", p0, 32'd0);
        chk("reset col/row", {c0, r0}, 32'd0);
        #1;
        rst_i = 1'b1;
        idle(1);

        // Single-pixel conversions, two-cycle latency.
        send(8'd0, 8'd0, 1'b0);
        idle(1);
        chk("lit valid 2cyc", 32'(v0), 32'd1);
        chk("lit fp(0)", p0, 32'h0000_0000);
        send(8'd1, 8'd255, 1'b0);
        idle(1);
        chk("lit fp(1)", p0, 32'h3F80_0000);
        chk("lit fp(255)", m0, 32'h437F_0000);
        chk("lit half(1)", 32'(p1), 32'h0000_3C00);
        chk("lit half(255)", 32'(m1), 32'h0000_5BF8);
        send(8'd3, 8'd128, 1'b0);
        idle(1);
        chk("lit fp(3)", p0, 32'h4040_0000);
        chk("lit fp(128)", m0, 32'h4300_0000);

        rst_i = 1'b0;
        idle(1);
        rst_i = 1'b1;
        idle(1);

        // One 4x3 frame with idle gaps, a 13th pixel, then fill out the frame.
        for (int i = 0; i < 24; i++) begin
            send(8'((i * 37 + 5) & 255), 8'((i * 91 + 200) & 255), i == 0);
            idle($urandom_range(0, 2));
        end
        idle(3);

        // Frame restarted by sof on its 6th pixel; stray sof without valid.
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                sof = 1'b1;
                idle(1);
                sof = 1'b0;
            end
            send(8'(i + 1), 8'(200 - i), (i == 0) || (i == 5));
            if (i == 5) begin
                idle(1);
                chk("lit restart err", 32'(f0), 32'd1);
                chk("lit restart coord", {c0, r0}, 32'd0);
            end
        end
        idle(2);

        // Asynchronous reset while valid_o is high.
        rp  = 8'd9;
        rm  = 8'd17;
        vin = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("lit valid before rst", 32'(v0), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("async rst valid_o", 32'(v0), 32'd0);
        chk("async rst data", p0 | m0, 32'd0);
        chk("async rst coord", {c0, r0}, 32'd0);
        vin = 1'b0;
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        idle(1);
        send(8'd7, 8'd7, 1'b0);
        idle(1);
        chk("lit post-rst coord", {c0, r0}, 32'd0);
        chk("lit post-rst valid", 32'(v0), 32'd1);
        idle(1);

        // Two back-to-back frames.
        rst_i = 1'b0;
        idle(1);
        rst_i = 1'b1;
        idle(1);
        eof_cnt  = 0;
        count_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rp  = 8'(i * 11);
            rm  = 8'(255 - i);
            vin = 1'b1;
            sof = (i % 12) == 0;
            @(posedge clk);
            #2;
        end
        vin = 1'b0;
        sof = 1'b0;
        idle(4);
        count_en = 1'b0;
        chk("eof pulse count", 32'(eof_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
